// File: rtl/control_filtro_pb_pkg.sv
// Shared codes for the low-pass filter sequencer: operand selects, state codes, enable indices.
// Pure declarations; no logic.
package control_filtro_pb_pkg;

    // Multiplicand select (selmuxS)
    localparam logic [2:0] S_FK    = 3'd0;
    localparam logic [2:0] S_FK1   = 3'd1;
    localparam logic [2:0] S_FK2   = 3'd2;
    localparam logic [2:0] S_YK    = 3'd3;
    localparam logic [2:0] S_UK    = 3'd4;
    localparam logic [2:0] S_ACUM1 = 3'd5;
    localparam logic [2:0] S_ACUM2 = 3'd6;
    localparam logic [2:0] S_ACUM3 = 3'd7;

    // Coefficient select (selmuxC): -a1, -a2, b0 (= b2), b1
    localparam logic [1:0] C_NA1 = 2'd0;
    localparam logic [1:0] C_NA2 = 2'd1;
    localparam logic [1:0] C_B0  = 2'd2;
    localparam logic [1:0] C_B1  = 2'd3;

    // Addend select (selmuxZ); codes 5..7 also read as zero in the datapath
    localparam logic [2:0] Z_ZERO  = 3'd0;
    localparam logic [2:0] Z_UK    = 3'd1;
    localparam logic [2:0] Z_ACUM1 = 3'd2;
    localparam logic [2:0] Z_ACUM2 = 3'd3;
    localparam logic [2:0] Z_ACUM3 = 3'd4;

    // Bit positions in the packed enable vector (en1 = bit 0 ... en7 = bit 6)
    localparam int EN_YK    = 0;
    localparam int EN_FK    = 1;
    localparam int EN_FK1   = 2;
    localparam int EN_FK2   = 3;
    localparam int EN_ACUM1 = 4;
    localparam int EN_ACUM2 = 5;
    localparam int EN_ACUM3 = 6;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SHIFT = 4'd1,
        ST_OP1   = 4'd2,
        ST_WR1   = 4'd3,
        ST_OP2   = 4'd4,
        ST_WR2   = 4'd5,
        ST_OP3   = 4'd6,
        ST_WR3   = 4'd7,
        ST_OP4   = 4'd8,
        ST_WR4   = 4'd9,
        ST_OP5   = 4'd10,
        ST_WR5   = 4'd11,
        ST_FIN   = 4'd12
    } state_t;

    function automatic state_t next_state(input state_t s, input logic start);
        case (s)
            ST_IDLE:  return start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: return ST_OP1;
            ST_OP1:   return ST_WR1;
            ST_WR1:   return ST_OP2;
            ST_OP2:   return ST_WR2;
            ST_WR2:   return ST_OP3;
            ST_OP3:   return ST_WR3;
            ST_WR3:   return ST_OP4;
            ST_OP4:   return ST_WR4;
            ST_WR4:   return ST_OP5;
            ST_OP5:   return ST_WR5;
            ST_WR5:   return ST_FIN;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/decod_ctrl_pb.sv
// State -> datapath control decoder for the filter sequencer.
// Purely combinational; no flow control.
module decod_ctrl_pb
    import control_filtro_pb_pkg::*;
(
    input  state_t     state,
    output logic [6:0] en,
    output logic [2:0] selmuxS,
    output logic [1:0] selmuxC,
    output logic [2:0] selmuxZ,
    output logic       busy,
    output logic       done
);

    // OPn and WRn share selects so the operands are stable while the MAC result registers.
    always_comb begin
        en      = '0;
        selmuxS = S_FK;
        selmuxC = C_NA1;
        selmuxZ = Z_ZERO;
        busy    = (state != ST_IDLE);
        done    = 1'b0;
        case (state)
            ST_SHIFT: begin
                en[EN_FK1] = 1'b1;
                en[EN_FK2] = 1'b1;
            end
            ST_OP1, ST_WR1: begin
                selmuxS         = S_FK1;
                selmuxC         = C_NA1;
                selmuxZ         = Z_UK;
                en[EN_ACUM1]    = (state == ST_WR1);
            end
            ST_OP2, ST_WR2: begin
                selmuxS         = S_FK2;
                selmuxC         = C_NA2;
                selmuxZ         = Z_ACUM1;
                en[EN_FK]       = (state == ST_WR2);
            end
            ST_OP3, ST_WR3: begin
                selmuxS         = S_FK;
                selmuxC         = C_B0;
                selmuxZ         = Z_ZERO;
                en[EN_ACUM2]    = (state == ST_WR3);
            end
            ST_OP4, ST_WR4: begin
                selmuxS         = S_FK1;
                selmuxC         = C_B1;
                selmuxZ         = Z_ACUM2;
                en[EN_ACUM3]    = (state == ST_WR4);
            end
            ST_OP5, ST_WR5: begin
                selmuxS         = S_FK2;
                selmuxC         = C_B0;
                selmuxZ         = Z_ACUM3;
                en[EN_YK]       = (state == ST_WR5);
            end
            ST_FIN:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_filtro_pb.sv
// Per-sample sequencer for the low-pass filter datapath (shift, five MACs, done).
// Latency start->done 12 cycles; sample period >= 13 cycles.
// No backpressure: start outside IDLE is dropped and latches overrun.
module control_filtro_pb
    import control_filtro_pb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       en5,
    output logic       en6,
    output logic       en7,
    output logic [2:0] selmuxS,
    output logic [1:0] selmuxC,
    output logic [2:0] selmuxZ,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    state_t     state;
    logic [6:0] en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            overrun <= 1'b0;
        end else begin
            state <= next_state(state, start);
            if (start && (state != ST_IDLE))
                overrun <= 1'b1;
        end
    end

    decod_ctrl_pb u_decod (
        .state   (state),
        .en      (en),
        .selmuxS (selmuxS),
        .selmuxC (selmuxC),
        .selmuxZ (selmuxZ),
        .busy    (busy),
        .done    (done)
    );

    assign en1 = en[EN_YK];
    assign en2 = en[EN_FK];
    assign en3 = en[EN_FK1];
    assign en4 = en[EN_FK2];
    assign en5 = en[EN_ACUM1];
    assign en6 = en[EN_ACUM2];
    assign en7 = en[EN_ACUM3];

endmodule

// File: doc/control_filtro_pb.md
# control_filtro_pb

Sequencing controller for the low-pass filter datapath: one FSM per sample that drives the datapath register enables (en1..en7) and operand mux selects (selmuxS, selmuxC, selmuxZ). On each `start` strobe from the sample-acquisition stage it shifts the state registers, runs five multiply-accumulate operations through the arithmetic unit (resultado = dato1·dato2 + dato3, registered, 1-cycle latency), then pulses `done` when y(k) is valid. It sits directly upstream of the filter datapath, in the same clock domain.

## Interface
Parameters: none. Select encodings and state codes live in `constantes.h`.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- start  in  1  sample-ready strobe; sampled only in IDLE
- en1..en7  out  1 each  write enables: yk, fk, fk1, fk2, acum1, acum2, acum3
- selmuxS  out  3  multiplicand select: 0 fk, 1 fk1, 2 fk2, 3 yk, 4 uk, 5 acum1, 6 acum2, 7 acum3
- selmuxC  out  2  coefficient select: 0 C0=−a1, 1 C1=−a2, 2 C2=b0(=b2), 3 C3=b1
- selmuxZ  out  3  addend select: 0 zero, 1 uk, 2 acum1, 3 acum2, 4 acum3, 5–7 zero
- busy  out  1  high from SHIFT through FIN
- done  out  1  one-cycle pulse; yk register holds y(k)
- overrun  out  1  sticky; set when start=1 while busy; cleared only by reset

## Operation
- Moore outputs decoded from the registered state. In IDLE all enables 0, all selects 0, busy 0, done 0.
- States and outputs, in order:
  - IDLE: go to SHIFT when start=1.
  - SHIFT: en3=en4=1, so fk1←fk and fk2←old fk1 in the same edge.
  - OP1/WR1: S=fk1, C=0, Z=uk; en5 in WR1. acum1 = −a1·f(k−1) + u(k).
  - OP2/WR2: S=fk2, C=1, Z=acum1; en2 in WR2. fk = f(k).
  - OP3/WR3: S=fk, C=2, Z=zero; en6 in WR3.
  - OP4/WR4: S=fk1, C=3, Z=acum2; en7 in WR4.
  - OP5/WR5: S=fk2, C=2, Z=acum3; en1 in WR5. yk = y(k).
  - FIN: done=1, then IDLE unconditionally.
- Selects are identical in OPn and WRn, so operands stay stable while the arithmetic result registers.
- Exactly one enable is high in each WR state. Enables are 0 in every OP state, in IDLE and in FIN.
- Width and arithmetic rules belong to the datapath. The controller is width-independent of `N`.
- A start pulse seen in any state other than IDLE, including FIN, is dropped and sets overrun.
- Reset in any state: the next state is IDLE and all outputs return to their IDLE values on the following cycle, including overrun=0. No partial write is completed.

## Timing
- start sampled high in IDLE at cycle t gives: SHIFT at t+1, WR1 at t+3, WR2 at t+5, WR3 at t+7, WR4 at t+9, WR5 at t+11, done at t+12, IDLE at t+13.
- Latency from start to done is 12 cycles. Minimum sample period is 13 cycles: start held high continuously restarts at t+13 and sets overrun.
- yk updates on the edge that ends WR5 and is stable while done=1.

## Structure
- `constantes.h` gains:
  - the S/C/Z select codes;
  - the 4-bit state codes (IDLE, SHIFT, OP1..WR5, FIN; 13 states);
  - the symbolic enable indices.
- One sub-module is natural: `decod_ctrl_pb`, a pure combinational state→{en1..en7, sel*, busy, done} decoder. The top holds the state register and the overrun flag.
- Integration wrapper: this block feeds the datapath directly by name-matched ports.

## Test plan
- Reset for 2 cycles, then idle 5 cycles -> all enables 0, selects 0, busy/done/overrun 0.
- start pulse at cycle 5 -> en3&en4 at 6, en5 at 8, en2 at 10, en6 at 12, en7 at 14, en1 at 16, done at 17, busy 6–17. Selects match the state list in OP/WR pairs. No other enables high.
- Integrated with the datapath and a reference model, using a1=−0.5, a2=0.25, b0=0.25, b1=0.5 and uk step 0→1.0 for 50 samples -> yk equals the model each done pulse. Final value ≈ DC gain 1.0/0.75.
- start pulse at cycle 10 while busy (sample started at 5) -> sequence unaffected, done at 17, overrun=1 from 11 and stays 1.
- Reset asserted in WR3 -> next cycle IDLE, en7/en1 never assert, done never pulses. A fresh start afterwards completes normally in 12 cycles.
- start held high 40 cycles -> done at t+12, t+25, t+38, and overrun set.
